// File: rtl/snake_body.sv
// snake_body -- segment store, move timer, growth and collision detection for
// the snake on the 40x30 playfield, plus registered per-cell body queries.
module snake_body #(
    parameter int MAX_LEN  = 16,
    parameter int MOVE_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dir_btn,
    input  logic       inc_len,
    input  logic [5:0] query_x,
    input  logic [5:0] query_y,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [4:0] length,
    output logic       query_hit,
    output logic       query_head,
    output logic       move_tick,
    output logic       game_over
);

    localparam int               CNT_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
    localparam logic [4:0]       LEN_MAX  = 5'(MAX_LEN);
    localparam logic [5:0]       X_WALL   = 6'd39;
    localparam logic [5:0]       Y_WALL   = 6'd29;

    typedef enum logic [1:0] {S_WAIT, S_RUN, S_OVER} state_t;
    // Opposite directions differ only in bit 0, which makes the reversal test an XOR.
    typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_t;

    state_t           r_state, w_state_nx;
    dir_t             r_dir, r_dir_next, w_btn_dir, w_dir_eff;
    logic [5:0]       r_seg_x [MAX_LEN];
    logic [5:0]       r_seg_y [MAX_LEN];
    logic [4:0]       r_len;
    logic [CNT_W-1:0] r_cnt;
    logic             r_grow_pending, r_inc_d, r_move_tick, r_game_over;
    logic             r_query_hit, r_query_head;
    logic             w_btn_any, w_press_ok, w_tick, w_do_move, w_do_over, w_inc_rise;
    logic             w_grow, w_wall_hit, w_self_hit, w_collide;
    logic             w_query_hit, w_query_head;
    logic [5:0]       w_next_x, w_next_y;
    logic [4:0]       w_body_lim;

    // Pick the highest-priority button and reject presses that reverse the snake.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_btn_any = |dir_btn;
        w_btn_dir = D_RIGHT;
        if (dir_btn[3])      w_btn_dir = D_UP;
        else if (dir_btn[2]) w_btn_dir = D_DOWN;
        else if (dir_btn[1]) w_btn_dir = D_LEFT;
        // Judge reversal against the direction that is current after this cycle.
        w_dir_eff  = w_tick ? r_dir_next : r_dir;
        w_press_ok = w_btn_any && (r_state != S_OVER) && ((w_btn_dir ^ w_dir_eff) != 2'b01);
    end

    // Candidate head cell one step along the buffered direction.
    always_comb begin
        w_next_x = r_seg_x[0];
        w_next_y = r_seg_y[0];
        case (r_dir_next)
            D_UP:    w_next_y = r_seg_y[0] - 6'd1;
            D_DOWN:  w_next_y = r_seg_y[0] + 6'd1;
            D_LEFT:  w_next_x = r_seg_x[0] - 6'd1;
            D_RIGHT: w_next_x = r_seg_x[0] + 6'd1;
        endcase
    end

    // Wall and self collision; the tail cell only blocks when it will not vacate.
    always_comb begin
        w_grow     = r_grow_pending && (r_len < LEN_MAX);
        w_body_lim = r_len - 5'd1 + {4'd0, w_grow};
        w_self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < w_body_lim) && (r_seg_x[i] == w_next_x) && (r_seg_y[i] == w_next_y))
                w_self_hit = 1'b1;
        end
        w_wall_hit = (w_next_x == 6'd0) || (w_next_x == X_WALL) ||
                     (w_next_y == 6'd0) || (w_next_y == Y_WALL);
        w_collide  = w_wall_hit || w_self_hit;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) r_state <= S_WAIT;
        else        r_state <= w_state_nx;
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_WAIT:  if (w_btn_any) w_state_nx = S_RUN;
            S_RUN:   if (w_tick && w_collide) w_state_nx = S_OVER;
            S_OVER:  w_state_nx = S_OVER;
            default: w_state_nx = S_WAIT;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        w_tick     = (r_state == S_RUN) && (r_cnt == CNT_LAST);
        w_do_move  = w_tick && !w_collide;
        w_do_over  = w_tick && w_collide;
        w_inc_rise = (r_state == S_RUN) && inc_len && !r_inc_d;
    end

    // Move-period counter, held at zero outside RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 r_cnt <= '0;
        else if (r_state != S_RUN)  r_cnt <= '0;
        else if (w_tick)            r_cnt <= '0;
        else                        r_cnt <= r_cnt + CNT_W'(1);
    end

    // Current direction follows the buffer only at a move.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dir      <= D_RIGHT;
            r_dir_next <= D_RIGHT;
        end else begin
            if (w_do_move)  r_dir      <= r_dir_next;
            if (w_press_ok) r_dir_next <= w_btn_dir;
        end
    end

    // Growth request: one per rising edge of inc_len, consumed by the next move.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inc_d        <= 1'b0;
            r_grow_pending <= 1'b0;
        end else begin
            r_inc_d <= inc_len;
            if (w_do_move)                          r_grow_pending <= w_inc_rise;
            else if (w_inc_rise && r_len < LEN_MAX) r_grow_pending <= 1'b1;
        end
    end

    // Segment shift register: new head enters at 0, the old tail is duplicated on growth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the segment array is reset because the start position is part of the game state.
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= 6'd0;
                r_seg_y[i] <= 6'd0;
            end
            r_seg_x[0] <= 6'd8;  r_seg_y[0] <= 6'd10;
            r_seg_x[1] <= 6'd7;  r_seg_y[1] <= 6'd10;
            r_seg_x[2] <= 6'd6;  r_seg_y[2] <= 6'd10;
        end else if (w_do_move) begin
            for (int i = 1; i < MAX_LEN; i++) begin
                r_seg_x[i] <= r_seg_x[i-1];
                r_seg_y[i] <= r_seg_y[i-1];
            end
            r_seg_x[0] <= w_next_x;
            r_seg_y[0] <= w_next_y;
        end
    end

    // Length, move pulse and sticky game-over flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len       <= 5'd3;
            r_move_tick <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_move_tick <= w_do_move;
            if (w_do_move && w_grow) r_len <= r_len + 5'd1;
            if (w_do_over)           r_game_over <= 1'b1;
        end
    end

    // Body query against live segments only.
    always_comb begin
        w_query_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < r_len) && (r_seg_x[i] == query_x) && (r_seg_y[i] == query_y))
                w_query_hit = 1'b1;
        end
        w_query_head = (r_seg_x[0] == query_x) && (r_seg_y[0] == query_y);
    end

    // Register query answers for the renderer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_query_hit  <= 1'b0;
            r_query_head <= 1'b0;
        end else begin
            r_query_hit  <= w_query_hit;
            r_query_head <= w_query_head;
        end
    end

    assign head_x     = r_seg_x[0];
    assign head_y     = r_seg_y[0];
    assign length     = r_len;
    assign query_hit  = r_query_hit;
    assign query_head = r_query_head;
    assign move_tick  = r_move_tick;
    assign game_over  = r_game_over;

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body -- directed scenarios for snake_body with MOVE_DIV = 4.
module tb_snake_body;

    localparam int MAX_LEN  = 16;
    localparam int MOVE_DIV = 4;

    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_LEFT  = 4'b0010;
    localparam logic [3:0] B_RIGHT = 4'b0001;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dir_btn;
    logic       inc_len;
    logic [5:0] query_x, query_y;
    logic [5:0] head_x, head_y;
    logic [4:0] length;
    logic       query_hit, query_head, move_tick, game_over;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    snake_body #(.MAX_LEN(MAX_LEN), .MOVE_DIV(MOVE_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .dir_btn    (dir_btn),
        .inc_len    (inc_len),
        .query_x    (query_x),
        .query_y    (query_y),
        .head_x     (head_x),
        .head_y     (head_y),
        .length     (length),
        .query_hit  (query_hit),
        .query_head (query_head),
        .move_tick  (move_tick),
        .game_over  (game_over)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        dir_btn = 4'b0;
        inc_len = 1'b0;
        query_x = 6'd0;
        query_y = 6'd0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic start_run(input logic [3:0] btn);
        dir_btn = btn;
        tick(1);
        dir_btn = 4'b0;
    endtask

    task automatic press(input logic [3:0] btn);
        dir_btn = btn;
        tick(1);
        dir_btn = 4'b0;
    endtask

    task automatic pulse_inc();
        inc_len = 1'b1;
        tick(1);
        inc_len = 1'b0;
    endtask

    // Wait (bounded) for the next move pulse; n returns cycles waited.
    task automatic wait_move(input string tag, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (move_tick !== 1'b1 && n < 4 * MOVE_DIV);
        check({tag, "_tick"}, move_tick, 1);
    endtask

    task automatic check_head(input string tag, input int x, input int y);
        check({tag, "_hx"}, head_x, x);
        check({tag, "_hy"}, head_y, y);
    endtask

    task automatic query(input int x, input int y);
        query_x = 6'(x);
        query_y = 6'(y);
        tick(1);
    endtask

    initial begin
        int n;
        int pulses;

        // ---------------- reset state ----------------
        do_reset();
        check_head("rst", 8, 10);
        check("rst_len",  length,     3);
        check("rst_go",   game_over,  0);
        check("rst_mt",   move_tick,  0);
        check("rst_qhit", query_hit,  0);
        check("rst_qhd",  query_head, 0);
        tick(6);
        check_head("wait_hold", 8, 10);
        check("wait_no_tick", move_tick, 0);

        // ---------------- start: moves every 4 cycles ----------------
        start_run(B_RIGHT);
        wait_move("mv1", n);
        check("mv1_period", n, 4);
        check_head("mv1", 9, 10);
        wait_move("mv2", n);
        check("mv2_period", n, 4);
        check_head("mv2", 10, 10);
        wait_move("mv3", n);
        check("mv3_period", n, 4);
        check_head("mv3", 11, 10);
        check("mv3_len", length, 3);

        // ---------------- reverse ignored, priority up > left ----------------
        press(B_LEFT);
        wait_move("rev", n);
        check_head("rev", 12, 10);
        press(B_UP | B_LEFT);
        wait_move("prio", n);
        check_head("prio", 12, 9);
        check("prio_len", length, 3);

        // ---------------- growth: held level grows once, then saturates ----------------
        do_reset();
        start_run(B_RIGHT);
        inc_len = 1'b1;
        wait_move("gr1", n);
        check_head("gr1", 9, 10);
        check("gr1_len", length, 4);
        query(6, 10);
        check("gr1_tail_kept", query_hit, 1);
        tick(5);
        inc_len = 1'b0;
        wait_move("gr_held", n);
        check_head("gr_held", 11, 10);
        check("gr_held_len", length, 4);
        for (int k = 1; k <= 12; k++) begin
            pulse_inc();
            wait_move("gr_loop", n);
            check("gr_loop_len", length, 4 + k);
        end
        check("gr_sat_len16", length, 16);
        pulse_inc();
        wait_move("gr_sat", n);
        check("gr_sat_len", length, 16);
        check_head("gr_sat", 24, 10);
        check("gr_sat_go", game_over, 0);

        // ---------------- wall collision going up ----------------
        do_reset();
        start_run(B_UP);
        for (int k = 1; k <= 9; k++) begin
            wait_move("wall_mv", n);
            check("wall_mv_hy", head_y, 10 - k);
        end
        check_head("wall_pre", 8, 1);
        check("wall_pre_go", game_over, 0);
        tick(MOVE_DIV);
        check("wall_go", game_over, 1);
        check("wall_mt", move_tick, 0);
        check_head("wall_frozen", 8, 1);
        pulses = 0;
        for (int k = 0; k < 4 * MOVE_DIV; k++) begin
            tick(1);
            if (move_tick === 1'b1) pulses++;
        end
        check("wall_no_more_ticks", pulses, 0);
        check_head("wall_still", 8, 1);
        check("wall_go_sticky", game_over, 1);
        reset = 1'b0;
        #1;
        check("wall_rst_go", game_over, 0);
        check_head("wall_rst", 8, 10);
        tick(1);
        reset = 1'b1;
        tick(1);

        // ---------------- self collision at length 5 ----------------
        do_reset();
        start_run(B_RIGHT);
        pulse_inc();
        wait_move("s5_g1", n);
        check("s5_g1_len", length, 4);
        pulse_inc();
        wait_move("s5_g2", n);
        check("s5_g2_len", length, 5);
        check_head("s5_g2", 10, 10);
        wait_move("s5_r", n);
        check_head("s5_r", 11, 10);
        press(B_DOWN);
        wait_move("s5_d", n);
        check_head("s5_d", 11, 11);
        press(B_LEFT);
        wait_move("s5_l", n);
        check_head("s5_l", 10, 11);
        press(B_UP);
        tick(MOVE_DIV - 1);
        check("s5_go", game_over, 1);
        check("s5_mt", move_tick, 0);
        check_head("s5_frozen", 10, 11);
        check("s5_len", length, 5);

        // ---------------- same loop at length 4: enters vacating tail ----------------
        do_reset();
        start_run(B_RIGHT);
        pulse_inc();
        wait_move("s4_g1", n);
        check("s4_g1_len", length, 4);
        wait_move("s4_r", n);
        check_head("s4_r", 10, 10);
        press(B_DOWN);
        wait_move("s4_d", n);
        check_head("s4_d", 10, 11);
        press(B_LEFT);
        wait_move("s4_l", n);
        check_head("s4_l", 9, 11);
        press(B_UP);
        wait_move("s4_u", n);
        check_head("s4_u", 9, 10);
        check("s4_go", game_over, 0);
        check("s4_len", length, 4);

        // ---------------- query and mid-run reset ----------------
        do_reset();
        query(7, 10);
        check("q710_hit",  query_hit,  1);
        check("q710_head", query_head, 0);
        query(8, 10);
        check("q810_hit",  query_hit,  1);
        check("q810_head", query_head, 1);
        query(0, 0);
        check("q00_hit",  query_hit,  0);
        check("q00_head", query_head, 0);
        query(6, 10);
        check("q610_hit", query_hit, 1);
        query(5, 10);
        check("q510_hit", query_hit, 0);
        start_run(B_RIGHT);
        wait_move("qr_mv", n);
        check_head("qr_mv", 9, 10);
        query(6, 10);
        check("q610_after_move", query_hit, 0);
        pulse_inc();
        tick(1);
        reset = 1'b0;
        #1;
        check_head("midrst", 8, 10);
        check("midrst_len", length, 3);
        check("midrst_go",  game_over, 0);
        tick(1);
        reset = 1'b1;
        tick(MOVE_DIV + 2);
        check_head("midrst_wait", 8, 10);
        check("midrst_no_tick", move_tick, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
